// File: rtl/hist_pkg.sv
// Shared definitions for the histogram sweep controller: FSM states and
// the hist_sig_mag read address width.
package hist_pkg;

  localparam int unsigned HIST_AW = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_FREEZE = 3'd3,
    ST_READ   = 3'd4,
    ST_HOLD   = 3'd5
  } hist_state_t;

endpackage

// File: rtl/hist_rd_seq.sv
// Read sequencer: steps the histogram read address, waits out the read
// latency and holds each result word in a valid/ready output register.
module hist_rd_seq
  import hist_pkg::*;
#(
  parameter int unsigned N_RES  = 14,
  parameter int unsigned RES_W  = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_rd,
  input  logic               i_hold,
  input  logic               i_abort,
  input  logic [RES_W-1:0]   i_result,
  input  logic               i_ready,
  output logic [HIST_AW-1:0] o_addr,
  output logic               o_lat_done,
  output logic               o_acc,
  output logic               o_last,
  output logic               o_valid,
  output logic [HIST_AW-1:0] o_res_addr,
  output logic [RES_W-1:0]   o_res_data
);

  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [LAT_W-1:0]   r_lat;
  logic [HIST_AW-1:0] r_addr;
  logic               r_valid;
  logic [HIST_AW-1:0] r_res_addr;
  logic [RES_W-1:0]   r_res_data;
  logic               w_lat_done;
  logic               w_acc;
  logic               w_last;

  assign w_lat_done = i_rd && (r_lat == LAT_W'(RD_LAT - 1));
  assign w_acc      = i_hold && r_valid && i_ready;
  assign w_last     = (r_addr == HIST_AW'(N_RES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat      <= '0;
      r_addr     <= '0;
      r_valid    <= 1'b0;
      r_res_addr <= '0;
      r_res_data <= '0;
    end else begin
      if (i_rd && !w_lat_done) r_lat <= r_lat + 1'b1;
      else                     r_lat <= '0;

      // Address parks at 0 outside a sweep so FREEZE already presents word 0.
      if (i_abort || !(i_rd || i_hold)) begin
        r_addr  <= '0;
        r_valid <= 1'b0;
      end else if (w_lat_done) begin
        r_valid    <= 1'b1;
        r_res_data <= i_result;
        r_res_addr <= r_addr;
      end else if (w_acc) begin
        r_valid <= 1'b0;
        r_addr  <= w_last ? '0 : r_addr + 1'b1;
      end
    end
  end

  assign o_addr     = r_addr;
  assign o_lat_done = w_lat_done;
  assign o_acc      = w_acc;
  assign o_last     = w_last;
  assign o_valid    = r_valid;
  assign o_res_addr = r_res_addr;
  assign o_res_data = r_res_data;

endmodule

// File: rtl/hist_sweep_ctrl.sv
// Measurement scheduler for hist_sig_mag: clear, accumulate for win_len
// clocks, freeze, then stream every result word over valid/ready.
module hist_sweep_ctrl
  import hist_pkg::*;
#(
  parameter int unsigned LINES   = 7,
  parameter int unsigned N_RES   = 2 * LINES,
  parameter int unsigned RES_W   = 32,
  parameter int unsigned WIN_W   = 24,
  parameter int unsigned CLR_CYC = 2,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [WIN_W-1:0]   win_len,
  output logic               hist_reset,
  output logic               hist_lock,
  output logic [HIST_AW-1:0] hist_addr,
  input  logic [RES_W-1:0]   hist_result,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [HIST_AW-1:0] res_addr,
  output logic [RES_W-1:0]   res_data,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  hist_state_t      r_state, w_nxt;
  logic [WIN_W-1:0] r_cnt;
  logic [WIN_W-1:0] r_win;
  logic [WIN_W-1:0] w_cnt_max;
  logic             r_done;
  logic             r_ovr;
  logic             w_lat_done, w_acc, w_last, w_sweep_end;

  hist_rd_seq #(
    .N_RES  (N_RES),
    .RES_W  (RES_W),
    .RD_LAT (RD_LAT)
  ) u_rd_seq (
    .clk        (clk),
    .reset      (reset),
    .i_rd       (r_state == ST_READ),
    .i_hold     (r_state == ST_HOLD),
    .i_abort    (abort),
    .i_result   (hist_result),
    .i_ready    (res_ready),
    .o_addr     (hist_addr),
    .o_lat_done (w_lat_done),
    .o_acc      (w_acc),
    .o_last     (w_last),
    .o_valid    (res_valid),
    .o_res_addr (res_addr),
    .o_res_data (res_data)
  );

  always_comb begin
    w_cnt_max = '0;
    case (r_state)
      ST_CLEAR:  w_cnt_max = WIN_W'(CLR_CYC - 1);
      ST_ACCUM:  w_cnt_max = r_win - 1'b1;
      ST_FREEZE: w_cnt_max = WIN_W'(RD_LAT - 1);
      default:   w_cnt_max = '0;
    endcase
  end

  assign w_sweep_end = (r_state == ST_HOLD) && w_acc && w_last && !abort;

  always_comb begin
    w_nxt = r_state;
    if (r_state != ST_IDLE && abort) begin
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (start) w_nxt = ST_CLEAR;
        ST_CLEAR:  if (r_cnt == w_cnt_max) w_nxt = ST_ACCUM;
        ST_ACCUM:  if (r_cnt == w_cnt_max) w_nxt = ST_FREEZE;
        ST_FREEZE: if (r_cnt == w_cnt_max) w_nxt = ST_READ;
        ST_READ:   if (w_lat_done) w_nxt = ST_HOLD;
        ST_HOLD: begin
          if (w_acc) begin
            if (!w_last)         w_nxt = ST_READ;
            else if (continuous) w_nxt = ST_CLEAR;
            else                 w_nxt = ST_IDLE;
          end
        end
        default:   w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_win   <= '0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (r_state == ST_CLEAR || r_state == ST_ACCUM || r_state == ST_FREEZE)
        r_cnt <= r_cnt + 1'b1;
      // Window length is captured on every CLEAR entry, including continuous restarts.
      if (w_nxt == ST_CLEAR && r_state != ST_CLEAR)
        r_win <= (win_len == '0) ? WIN_W'(1) : win_len;
      r_done <= w_sweep_end;
      if (start) r_ovr <= (r_state != ST_IDLE);
    end
  end

  assign hist_reset = (r_state == ST_CLEAR);
  assign hist_lock  = (r_state == ST_FREEZE) || (r_state == ST_READ) || (r_state == ST_HOLD);
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign overrun    = r_ovr;

endmodule

// File: doc/hist_sweep_ctrl.md
Name: hist_sweep_ctrl

Overview:
- Measurement scheduler for the hist_sig_mag sign/magnitude histogram block.
- Runs one measurement window at a time: clears the histogram, accumulates for a programmable number of clocks, then freezes it with lock.
- While frozen, sweeps the histogram read address and streams each result word out over a valid/ready handshake.
- Sits between the register/bus layer and hist_sig_mag in the imitator DSP path.

Parameters:
- LINES, 7, number of sig/mag lines in the controlled hist_sig_mag; informational, sets the N_RES default.
- N_RES, 2*LINES, result words read per sweep (addresses 0..N_RES-1); range 1..256.
- RES_W, 32, hist_result / res_data width.
- WIN_W, 24, window-length counter width.
- CLR_CYC, 2, cycles hist_reset is held high per window.
- RD_LAT, 2, cycles from hist_addr change to hist_result valid.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a measurement when idle.
- abort  in  1  one-cycle pulse; terminates the current measurement.
- continuous  in  1  when 1, automatically restart after each sweep.
- win_len  in  WIN_W  accumulation length in clocks; sampled at CLEAR entry.
- hist_reset  out  1  active-high clear to hist_sig_mag.
- hist_lock  out  1  freezes the histogram counters.
- hist_addr  out  8  read address to hist_sig_mag.
- hist_result  in  RES_W  read data from hist_sig_mag.
- res_valid  out  1  result word available.
- res_ready  in  1  consumer accepts the word.
- res_addr  out  8  address of the current result word.
- res_data  out  RES_W  registered result word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.
- overrun  out  1  sticky; set by start while busy, cleared by the next accepted start in IDLE.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM to IDLE, all counters 0.
- FSM states: IDLE, CLEAR, ACCUM, FREEZE, READ, HOLD.
- IDLE: start -> CLEAR; overrun cleared; win_len latched into win_q (win_len=0 is treated as 1).
- CLEAR: hist_reset=1 for exactly CLR_CYC cycles, hist_lock=0, then -> ACCUM.
- ACCUM: hist_lock=0; remains exactly win_q cycles, then -> FREEZE.
- FREEZE: hist_lock=1; hist_addr=0; waits RD_LAT cycles, then -> READ.
- READ: hist_lock=1; after RD_LAT cycles at the current hist_addr, register hist_result into res_data, set res_addr=hist_addr, assert res_valid, -> HOLD.
- HOLD: res_valid, res_data and res_addr stay stable until res_valid & res_ready.
  - On acceptance with more words remaining: deassert res_valid, hist_addr+1, -> READ.
  - On acceptance of word N_RES-1: done=1 for one cycle, hist_lock -> 0. If continuous, -> CLEAR (re-latching win_len); otherwise -> IDLE.
- res_ready may be held high; the minimum cadence is one word per RD_LAT+1 cycles.
- Ready before valid has no effect.
- start while busy: ignored and sets overrun.
- abort in any non-IDLE state: next cycle -> IDLE, hist_lock=0, res_valid=0, no done. abort has priority over start and over handshake completion in the same cycle.
- continuous deasserted mid-window: the current sweep completes, then -> IDLE.
- hist_addr never exceeds N_RES-1; no wrap within a sweep.
- The window counter is WIN_W bits. win_len = 2^WIN_W-1 is a legal maximum with no overflow.

Decomposition:
- Shared package hist_pkg: FSM state encoding constants and the hist address width (8).
- One natural sub-module: hist_rd_seq, covering the READ/HOLD address stepping, latency wait and valid/ready register stage. The top FSM owns CLEAR/ACCUM/FREEZE.

Test Plan:
- Reset then start, win_len=10, N_RES=14, res_ready=1: hist_reset high 2 cycles, lock low exactly 10 cycles, then 14 words with res_addr 0..13 in order, done pulse once, busy low after.
- Backpressure: res_ready low for 20 cycles on word 5: res_data/res_addr stay frozen and hist_lock stays 1; word 5 delivered once, no skip or duplicate.
- continuous=1, win_len changed from 10 to 4 during READ: the second window lasts 4 cycles, with no IDLE gap between done and hist_reset.
- start pulsed during ACCUM: overrun=1, the measurement proceeds unchanged; the next start in IDLE clears overrun.
- abort during HOLD at word 3: next cycle busy=0, res_valid=0, hist_lock=0, no done. A following start runs a full sweep from address 0.
- reset driven low during ACCUM: all outputs 0 immediately (asynchronous), FSM in IDLE after release. win_len=0 run: lock low exactly 1 cycle.
